ifu_fetch_ctrl: RTL
===================

Name: ifu_fetch_ctrl

Overview:
Instruction-fetch controller in front of the combinational instruction ROM (32-bit words, word-indexed by a 10-bit address).
- Owns the PC and sequences ROM reads.
- Buffers fetched words in a 2-entry queue with valid/ready handoff to decode.
- Handles branch/jump redirects by flushing the queue and reloading the PC.
- Flags out-of-range and misaligned fetch addresses.

Parameters:
PC_RESET, 32'h0000_3000, PC value after reset; byte address mapped to ROM word 0
ROM_AW, 10, ROM word-address width; ROM spans 4*2^ROM_AW bytes starting at PC_RESET

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
fetch_en  input  1  global fetch enable; 0 = hold PC, no push (queue may still drain)
rom_addr  output  ROM_AW  ROM word index = (pc - PC_RESET)[ROM_AW+1:2], combinational from pc
rom_data  input  32  ROM word at rom_addr, same cycle (combinational read)
redirect_valid  input  1  branch/jump taken; load redirect_pc, flush queue
redirect_pc  input  32  new fetch byte address
instr_valid  output  1  queue head valid
instr_ready  input  1  decode accepts head this cycle
instr  output  32  queue head instruction word
instr_pc  output  32  byte PC of queue head
fetch_fault  output  1  sticky: PC misaligned or outside ROM window

Behaviour:
- State: pc[31:0], 2-entry queue of {pc, word}, count in 0..2, fault flag. All updates occur on rising clk.
- Reset (reset=1 at an edge), overriding all other inputs:
  - pc <= PC_RESET; count <= 0; fault <= 0.
  - Outputs: instr_valid=0, instr=0, instr_pc=0, fetch_fault=0.
  - Queue storage is cleared to 0.
- Derived signals:
  - off = pc - PC_RESET (32-bit wrap).
  - bad = (pc[1:0] != 0) | (off >= 4*2^ROM_AW), with the compare done unsigned.
  - pop = instr_valid & instr_ready.
  - room = (count < 2) | pop.
- Push condition: fetch_en & !redirect_valid & !fault & !bad & room.
- On push:
  - Enqueue {pc, rom_data} at the tail.
  - pc <= pc + 4 (32-bit wrap; a wrapped or past-end PC is caught by bad on the next cycle).
- Fault:
  - If fetch_en & !redirect_valid & !fault & bad: fault <= 1, no push, pc holds.
  - fetch_fault = fault. It stays set until a redirect or reset.
  - The queue continues to drain while fault is set.
- Pop: the head is removed on pop. Push and pop in the same cycle are legal at count=0, 1 or 2:
  - At count=0 the push lands and count becomes 1; the pop is not possible since instr_valid=0.
  - At count=2 with pop, count stays 2.
- Redirect (redirect_valid=1 at an edge, reset=0) has highest priority:
  - count <= 0; pc <= redirect_pc; fault <= 0.
  - Any push that cycle is suppressed.
  - A simultaneous pop is treated as a completed handoff by decode, then the queue is cleared anyway.
- Outputs are driven from registered queue state, with no combinational path from rom_data or instr_ready:
  - instr_valid = (count != 0).
  - instr and instr_pc = head entry.
  - When count=0, instr and instr_pc hold their last values; they are 0 after reset.
- Stability: while instr_valid & !instr_ready and no redirect, instr and instr_pc must not change.
- Latency:
  - Reset released at edge E0 (reset=0 sampled at E1): push at E1, instr_valid=1 after E1 with instr_pc=PC_RESET.
  - Redirect at edge Er: first redirected word pushed at Er+1, visible after Er+1 (1-cycle bubble).
- Throughput: one instruction per cycle sustained when instr_ready=1 continuously.
- fetch_en=0: no push, no fault evaluation, pc holds; pops and redirects still act.

Test Plan:
- Reset then instr_ready=1, fetch_en=1, ROM word k = 32'h1000_0000+k -> after E1, instr_valid=1, instr_pc=32'h3000, instr=32'h1000_0000; then one word per cycle with instr_pc +4 each cycle.
- instr_ready=0 for 5 cycles after reset -> count saturates at 2, instr_valid stays 1, instr=32'h1000_0000 stable, pc=32'h3008 held, rom_addr=2; release ready -> entries 0, 1, 2 delivered in order with no gaps.
- Redirect at queue full, redirect_pc=32'h3040, simultaneous pop -> next cycle instr_valid=0, the cycle after instr_pc=32'h3040 and instr=32'h1000_0010, and no stale entry ever appears.
- Sequential fetch up to pc=32'h3FFC with ROM_AW=10 -> word 1023 delivered; at pc=32'h4000, fetch_fault=1, no further push, queue drains; redirect to 32'h3000 clears fault and fetch resumes.
- redirect_pc=32'h3002 -> fetch_fault=1 the cycle after redirect load, instr_valid stays 0; assert reset mid-stream at count=2 -> next cycle instr_valid=0, instr=0, instr_pc=0, fetch_fault=0, pc=32'h3000.

Source files
------------

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, reads the combinational ROM,
// buffers fetched words in a 2-entry queue for decode, handles redirects
// and flags fetch addresses that are misaligned or outside the ROM window.
module ifu_fetch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned ROM_AW   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    output logic              fetch_fault
);

    // Size of the ROM window in bytes; 33 bits so the compare never overflows.
    localparam logic [32:0] ROM_BYTES = 33'd4 << ROM_AW;

    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic        fault_q, fault_d;
    // Entry 0 is always the head; entry 1 is the second-oldest word.
    logic [31:0] ent0_pc_q, ent0_pc_d, ent0_word_q, ent0_word_d;
    logic [31:0] ent1_pc_q, ent1_pc_d, ent1_word_q, ent1_word_d;

    logic [31:0] off;
    logic        bad;
    logic        pop;
    logic        room;
    logic        eval;
    logic        push;
    logic        fault_set;

    // Address decode and push/fault qualification.
    always_comb begin
        off       = pc_q - PC_RESET;
        rom_addr  = off[ROM_AW+1:2];
        bad       = (pc_q[1:0] != 2'b00) | ({1'b0, off} >= ROM_BYTES);
        pop       = instr_valid & instr_ready;
        room      = (count_q != 2'd2) | pop;
        eval      = fetch_en & ~redirect_valid & ~fault_q;
        push      = eval & ~bad & room;
        fault_set = eval & bad;
    end

    // Outputs come only from registered queue state.
    always_comb begin
        instr_valid = (count_q != 2'd0);
        instr       = ent0_word_q;
        instr_pc    = ent0_pc_q;
        fetch_fault = fault_q;
    end

    // Next-state: redirect wins, otherwise push/pop update the queue.
    always_comb begin
        pc_d        = pc_q;
        count_d     = count_q;
        fault_d     = fault_q;
        ent0_pc_d   = ent0_pc_q;
        ent0_word_d = ent0_word_q;
        ent1_pc_d   = ent1_pc_q;
        ent1_word_d = ent1_word_q;

        if (redirect_valid) begin
            // A same-cycle pop is already taken by decode; the queue is dropped
            // but the storage is kept so instr/instr_pc hold their last values.
            count_d = 2'd0;
            pc_d    = redirect_pc;
            fault_d = 1'b0;
        end else begin
            if (push) begin
                pc_d = pc_q + 32'd4;
            end
            if (fault_set) begin
                fault_d = 1'b1;
            end
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        ent0_pc_d   = pc_q;
                        ent0_word_d = rom_data;
                    end else begin
                        ent1_pc_d   = pc_q;
                        ent1_word_d = rom_data;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    // Popping the last entry leaves the head registers untouched.
                    if (count_q == 2'd2) begin
                        ent0_pc_d   = ent1_pc_q;
                        ent0_word_d = ent1_word_q;
                    end
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_pc_d   = pc_q;
                        ent0_word_d = rom_data;
                    end else begin
                        ent0_pc_d   = ent1_pc_q;
                        ent0_word_d = ent1_word_q;
                        ent1_pc_d   = pc_q;
                        ent1_word_d = rom_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= PC_RESET;
            count_q     <= 2'd0;
            fault_q     <= 1'b0;
            ent0_pc_q   <= 32'd0;
            ent0_word_q <= 32'd0;
            ent1_pc_q   <= 32'd0;
            ent1_word_q <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            count_q     <= count_d;
            fault_q     <= fault_d;
            ent0_pc_q   <= ent0_pc_d;
            ent0_word_q <= ent0_word_d;
            ent1_pc_q   <= ent1_pc_d;
            ent1_word_q <= ent1_word_d;
        end
    end

endmodule
